wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly downstream of the integer pipe (ip), the load/store pipe (lsp) and the multiply/divide pipe (md).
- Each cycle, selects at most one completed result using valid/ready handshakes, with high-priority first and round-robin otherwise.
- Registers the selected result onto the register-file write port and the retire interface.
- Keeps a retired-instruction counter.

Parameters:
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ip_wb_dst  in  5  integer pipe destination register
- ip_wb_result  in  64  integer pipe result
- ip_wb_pc  in  64  integer pipe instruction PC
- ip_wb_wb_en  in  1  integer pipe register write enable
- ip_wb_hipri  in  1  integer pipe high-priority request (branch)
- ip_wb_valid  in  1  integer pipe result valid
- ip_wb_ready  out  1  integer pipe result accepted this cycle
- lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en, lsp_wb_hipri, lsp_wb_valid  in  5/64/64/1/1/1  load/store pipe, same meaning as ip_*
- lsp_wb_ready  out  1  load/store pipe result accepted this cycle
- md_wb_dst, md_wb_result, md_wb_pc, md_wb_wb_en, md_wb_hipri, md_wb_valid  in  5/64/64/1/1/1  mul/div pipe, same meaning as ip_*
- md_wb_ready  out  1  mul/div pipe result accepted this cycle
- wb_stall  in  1  freeze writeback; no grants issued
- rf_wen  out  1  register file write enable (registered)
- rf_wdst  out  5  register file write address (registered)
- rf_wdata  out  64  register file write data (registered)
- wb_ix_forwarding  out  64  equals rf_wdata; forwarding path to issue
- wb_retire_valid  out  1  one instruction retired (registered)
- wb_retire_pc  out  64  PC of the retired instruction (registered)
- wb_retire_src  out  2  source of the retired instruction: 0=ip, 1=lsp, 2=md
- wb_retire_count  out  CNT_W  total instructions retired

Behaviour:
- Reset (async, rst=1): rf_wen=0, rf_wdst=0, rf_wdata=0, wb_retire_valid=0, wb_retire_pc=0, wb_retire_src=0, wb_retire_count=0, rr_ptr=0. Ready outputs are combinational: all 0 while wb_stall=1 or when no source is valid.
- Source indices: ip=0, lsp=1, md=2. A source is eligible when its valid=1.
- Grant is combinational, at most one per cycle, and only when wb_stall=0:
  - If any eligible source has hipri=1, grant the lowest-index such source.
  - Otherwise grant the first eligible source searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- ready for the granted source = 1; ready for all other sources = 0. The ready outputs depend only on the valid, hipri and wb_stall inputs and on rr_ptr, never on the payload inputs.
- Fairness: on any grant, rr_ptr <= (granted index + 1) mod 3, including hipri grants. With no grant, rr_ptr holds.
- Latency is 1 cycle: a grant at edge N produces outputs after edge N:
  - rf_wen = wb_en && (dst != 0). Writes to x0 are suppressed, but the instruction still retires.
  - rf_wdst = dst; rf_wdata = result.
  - wb_retire_valid = 1; wb_retire_pc = pc; wb_retire_src = granted index.
- No grant in a cycle: rf_wen <= 0 and wb_retire_valid <= 0. rf_wdst, rf_wdata, wb_retire_pc and wb_retire_src hold their values.
- wb_retire_count increments by 1 per grant and wraps modulo 2^CNT_W.
- Sources hold valid and payload stable until ready=1. The block neither buffers nor drops results.
- wb_stall=1 overrides hipri.
- Reset asserted mid-operation: outputs clear immediately. Any in-flight grant is lost; upstream stages are reset in the same domain.

Test Plan:
- Single source: ip valid with dst=5, result=0x1234, pc=0x8000_0000, wb_en=1 -> ip_wb_ready=1 same cycle; next cycle rf_wen=1, rf_wdst=5, rf_wdata=0x1234, wb_retire_pc=0x8000_0000, wb_retire_src=0, count=1.
- x0 suppression: lsp valid with dst=0, wb_en=1 -> next cycle rf_wen=0, wb_retire_valid=1, count increments.
- Round-robin: ip, lsp and md held valid for 6 cycles, no hipri, starting from reset -> grant order ip, lsp, md, ip, lsp, md; count=6.
- Priority: ip hipri=1, lsp and md valid, rr_ptr=1 -> ip granted first; rr_ptr becomes 1; lsp granted next cycle.
- Stall: all three sources valid, wb_stall=1 for 3 cycles -> all readys 0, rf_wen=0, count unchanged; after wb_stall falls, grants resume from the held rr_ptr.
- Async reset: assert rst between clock edges after 2 retirements -> rf_wen, wb_retire_valid and wb_retire_count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one completed result per cycle from ip/lsp/md
// (high-priority first, round-robin otherwise) and registers it onto the RF write and retire ports.
module wb_arbiter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [4:0]       ip_wb_dst,
  input  logic [63:0]      ip_wb_result,
  input  logic [63:0]      ip_wb_pc,
  input  logic             ip_wb_wb_en,
  input  logic             ip_wb_hipri,
  input  logic             ip_wb_valid,
  output logic             ip_wb_ready,

  input  logic [4:0]       lsp_wb_dst,
  input  logic [63:0]      lsp_wb_result,
  input  logic [63:0]      lsp_wb_pc,
  input  logic             lsp_wb_wb_en,
  input  logic             lsp_wb_hipri,
  input  logic             lsp_wb_valid,
  output logic             lsp_wb_ready,

  input  logic [4:0]       md_wb_dst,
  input  logic [63:0]      md_wb_result,
  input  logic [63:0]      md_wb_pc,
  input  logic             md_wb_wb_en,
  input  logic             md_wb_hipri,
  input  logic             md_wb_valid,
  output logic             md_wb_ready,

  input  logic             wb_stall,

  output logic             rf_wen,
  output logic [4:0]       rf_wdst,
  output logic [63:0]      rf_wdata,
  output logic [63:0]      wb_ix_forwarding,
  output logic             wb_retire_valid,
  output logic [63:0]      wb_retire_pc,
  output logic [1:0]       wb_retire_src,
  output logic [CNT_W-1:0] wb_retire_count
);

  localparam int unsigned NSRC   = 3;
  localparam int unsigned DST_W  = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 2;

  localparam logic [IDX_W-1:0] SRC_IP  = 2'd0;
  localparam logic [IDX_W-1:0] SRC_LSP = 2'd1;
  localparam logic [IDX_W-1:0] SRC_MD  = 2'd2;

  typedef struct packed {
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] pc;
    logic              wb_en;
  } wb_req_t;

  logic [NSRC-1:0]  valid_c;
  logic [NSRC-1:0]  hipri_c;
  logic [NSRC-1:0]  urgent_c;
  logic             gnt_vld_c;
  logic [IDX_W-1:0] gnt_idx_c;
  logic [2:0]       cand_c;
  logic             found_c;
  wb_req_t          sel_c;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             rf_wen_q, rf_wen_d;
  logic [DST_W-1:0] rf_wdst_q, rf_wdst_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic             retire_valid_q, retire_valid_d;
  logic [DATA_W-1:0] retire_pc_q, retire_pc_d;
  logic [IDX_W-1:0] retire_src_q, retire_src_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;

  assign valid_c  = {md_wb_valid, lsp_wb_valid, ip_wb_valid};
  assign hipri_c  = {md_wb_hipri, lsp_wb_hipri, ip_wb_hipri};
  assign urgent_c = valid_c & hipri_c;

  // Grant selection: uses only valid/hipri/stall and rr_ptr, never payload.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = SRC_IP;
    cand_c    = 3'd0;
    found_c   = 1'b0;
    if (!wb_stall) begin
      if (|urgent_c) begin
        gnt_vld_c = 1'b1;
        if (urgent_c[0])      gnt_idx_c = SRC_IP;
        else if (urgent_c[1]) gnt_idx_c = SRC_LSP;
        else                  gnt_idx_c = SRC_MD;
      end else begin
        for (int k = 0; k < int'(NSRC); k++) begin
          cand_c = 3'(rr_ptr_q) + 3'(k);
          if (cand_c >= 3'(NSRC)) cand_c = cand_c - 3'(NSRC);
          if (!found_c && valid_c[cand_c[1:0]]) begin
            found_c   = 1'b1;
            gnt_vld_c = 1'b1;
            gnt_idx_c = cand_c[1:0];
          end
        end
      end
    end
  end

  assign ip_wb_ready  = gnt_vld_c && (gnt_idx_c == SRC_IP);
  assign lsp_wb_ready = gnt_vld_c && (gnt_idx_c == SRC_LSP);
  assign md_wb_ready  = gnt_vld_c && (gnt_idx_c == SRC_MD);

  // Payload mux for the granted source.
  always_comb begin
    sel_c = '0;
    case (gnt_idx_c)
      SRC_LSP: sel_c = '{dst: lsp_wb_dst, result: lsp_wb_result, pc: lsp_wb_pc, wb_en: lsp_wb_wb_en};
      SRC_MD:  sel_c = '{dst: md_wb_dst,  result: md_wb_result,  pc: md_wb_pc,  wb_en: md_wb_wb_en};
      default: sel_c = '{dst: ip_wb_dst,  result: ip_wb_result,  pc: ip_wb_pc,  wb_en: ip_wb_wb_en};
    endcase
  end

  // Next-state: strobes drop without a grant, data fields hold.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    rf_wen_d       = 1'b0;
    rf_wdst_d      = rf_wdst_q;
    rf_wdata_d     = rf_wdata_q;
    retire_valid_d = 1'b0;
    retire_pc_d    = retire_pc_q;
    retire_src_d   = retire_src_q;
    retire_count_d = retire_count_q;
    if (gnt_vld_c) begin
      rf_wen_d       = sel_c.wb_en && (sel_c.dst != '0);
      rf_wdst_d      = sel_c.dst;
      rf_wdata_d     = sel_c.result;
      retire_valid_d = 1'b1;
      retire_pc_d    = sel_c.pc;
      retire_src_d   = gnt_idx_c;
      retire_count_d = retire_count_q + CNT_W'(1);
      rr_ptr_d       = (gnt_idx_c == SRC_MD) ? SRC_IP : gnt_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= SRC_IP;
      rf_wen_q       <= 1'b0;
      rf_wdst_q      <= '0;
      rf_wdata_q     <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      retire_src_q   <= '0;
      retire_count_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rf_wen_q       <= rf_wen_d;
      rf_wdst_q      <= rf_wdst_d;
      rf_wdata_q     <= rf_wdata_d;
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      retire_src_q   <= retire_src_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign rf_wen           = rf_wen_q;
  assign rf_wdst          = rf_wdst_q;
  assign rf_wdata         = rf_wdata_q;
  assign wb_ix_forwarding = rf_wdata_q;
  assign wb_retire_valid  = retire_valid_q;
  assign wb_retire_pc     = retire_pc_q;
  assign wb_retire_src    = retire_src_q;
  assign wb_retire_count  = retire_count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single grant, x0 suppression,
// round-robin, priority, stall and asynchronous reset.
module tb_wb_arbiter;

  localparam int unsigned CNT_W = 64;

  logic clk, rst;
  logic [4:0]  ip_dst, lsp_dst, md_dst;
  logic [63:0] ip_res, lsp_res, md_res;
  logic [63:0] ip_pc, lsp_pc, md_pc;
  logic ip_en, lsp_en, md_en;
  logic ip_hp, lsp_hp, md_hp;
  logic ip_v, lsp_v, md_v;
  logic ip_rdy, lsp_rdy, md_rdy;
  logic wb_stall;
  logic rf_wen;
  logic [4:0] rf_wdst;
  logic [63:0] rf_wdata, wb_ix_forwarding, wb_retire_pc;
  logic wb_retire_valid;
  logic [1:0] wb_retire_src;
  logic [CNT_W-1:0] wb_retire_count;
  logic [2:0] rdy;

  int tests_run = 0;
  int tests_failed = 0;

  assign rdy = {md_rdy, lsp_rdy, ip_rdy};

  wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ip_wb_dst(ip_dst), .ip_wb_result(ip_res), .ip_wb_pc(ip_pc), .ip_wb_wb_en(ip_en),
    .ip_wb_hipri(ip_hp), .ip_wb_valid(ip_v), .ip_wb_ready(ip_rdy),
    .lsp_wb_dst(lsp_dst), .lsp_wb_result(lsp_res), .lsp_wb_pc(lsp_pc), .lsp_wb_wb_en(lsp_en),
    .lsp_wb_hipri(lsp_hp), .lsp_wb_valid(lsp_v), .lsp_wb_ready(lsp_rdy),
    .md_wb_dst(md_dst), .md_wb_result(md_res), .md_wb_pc(md_pc), .md_wb_wb_en(md_en),
    .md_wb_hipri(md_hp), .md_wb_valid(md_v), .md_wb_ready(md_rdy),
    .wb_stall(wb_stall),
    .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata),
    .wb_ix_forwarding(wb_ix_forwarding),
    .wb_retire_valid(wb_retire_valid), .wb_retire_pc(wb_retire_pc),
    .wb_retire_src(wb_retire_src), .wb_retire_count(wb_retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ip_dst = '0;  ip_res = '0;  ip_pc = '0;  ip_en = 0;  ip_hp = 0;  ip_v = 0;
    lsp_dst = '0; lsp_res = '0; lsp_pc = '0; lsp_en = 0; lsp_hp = 0; lsp_v = 0;
    md_dst = '0;  md_res = '0;  md_pc = '0;  md_en = 0;  md_hp = 0;  md_v = 0;
    wb_stall = 0;
  endtask

  // Stimulus only: drive one source's handshake and payload.
  task automatic set_src(input int s, input logic v, input logic hp, input logic [4:0] dst,
                         input logic [63:0] res, input logic [63:0] pc, input logic en);
    case (s)
      0: begin ip_v = v;  ip_hp = hp;  ip_dst = dst;  ip_res = res;  ip_pc = pc;  ip_en = en;  end
      1: begin lsp_v = v; lsp_hp = hp; lsp_dst = dst; lsp_res = res; lsp_pc = pc; lsp_en = en; end
      default: begin md_v = v; md_hp = hp; md_dst = dst; md_res = res; md_pc = pc; md_en = en; end
    endcase
  endtask

  // Pulse reset and return at posedge+1.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #12;
    tests_run++;
    if ({rf_wen, wb_retire_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_strobes got=%b want=00", {rf_wen, wb_retire_valid});
    end
    tests_run++;
    if ({rf_wdst, rf_wdata, wb_retire_pc, wb_retire_src} !== '0) begin
      tests_failed++; $display("FAIL reset_data got wdst=%0d wdata=%h pc=%h src=%0d want all 0",
                               rf_wdst, rf_wdata, wb_retire_pc, wb_retire_src);
    end
    tests_run++;
    if (wb_retire_count !== '0) begin
      tests_failed++; $display("FAIL reset_count got=%0d want=0", wb_retire_count);
    end
    tests_run++;
    if (rdy !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ready got=%b want=000", rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_src(0, 1, 0, 5'd5, 64'h1234, 64'h8000_0000, 1);
    #1;
    tests_run++;
    if (rdy !== 3'b001) begin
      tests_failed++; $display("FAIL single_ready got=%b want=001", rdy);
    end
    next_cycle();
    clear_inputs();
    tests_run++;
    if ({rf_wen, wb_retire_valid, rf_wdst, wb_retire_src} !== {1'b1, 1'b1, 5'd5, 2'd0}) begin
      tests_failed++; $display("FAIL single_ctrl got wen=%b rv=%b dst=%0d src=%0d want 1 1 5 0",
                               rf_wen, wb_retire_valid, rf_wdst, wb_retire_src);
    end
    tests_run++;
    if ({rf_wdata, wb_ix_forwarding, wb_retire_pc} !== {64'h1234, 64'h1234, 64'h8000_0000}) begin
      tests_failed++; $display("FAIL single_data got wdata=%h fwd=%h pc=%h want 1234 1234 80000000",
                               rf_wdata, wb_ix_forwarding, wb_retire_pc);
    end
    tests_run++;
    if (wb_retire_count !== 64'd1) begin
      tests_failed++; $display("FAIL single_count got=%0d want=1", wb_retire_count);
    end
  endtask

  task automatic test_x0();
    set_src(1, 1, 0, 5'd0, 64'hBEEF, 64'h8000_0004, 1);
    #1;
    tests_run++;
    if (rdy !== 3'b010) begin
      tests_failed++; $display("FAIL x0_ready got=%b want=010", rdy);
    end
    next_cycle();
    clear_inputs();
    tests_run++;
    if ({rf_wen, wb_retire_valid, wb_retire_src, wb_retire_count} !== {1'b0, 1'b1, 2'd1, 64'd2}) begin
      tests_failed++; $display("FAIL x0_retire got wen=%b rv=%b src=%0d cnt=%0d want 0 1 1 2",
                               rf_wen, wb_retire_valid, wb_retire_src, wb_retire_count);
    end
    next_cycle();
    tests_run++;
    if ({rf_wen, wb_retire_valid, rf_wdata, wb_retire_pc, wb_retire_count} !==
        {1'b0, 1'b0, 64'hBEEF, 64'h8000_0004, 64'd2}) begin
      tests_failed++; $display("FAIL idle_hold got wen=%b rv=%b wdata=%h pc=%h cnt=%0d want 0 0 beef 80000004 2",
                               rf_wen, wb_retire_valid, rf_wdata, wb_retire_pc, wb_retire_count);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_rdy;
    logic [63:0] exp_data;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < 3; s++)
        set_src(s, 1, 0, 5'(s + 1), 64'h1000 * 64'(s + 1) + 64'(c), 64'h9000 + 64'(c), 1);
      exp_rdy  = 3'b001 << (c % 3);
      exp_data = 64'h1000 * 64'((c % 3) + 1) + 64'(c);
      #1;
      tests_run++;
      if (rdy !== exp_rdy) begin
        tests_failed++; $display("FAIL rr_ready[%0d] got=%b want=%b", c, rdy, exp_rdy);
      end
      next_cycle();
      tests_run++;
      if ({wb_retire_src, rf_wdata} !== {2'(c % 3), exp_data}) begin
        tests_failed++; $display("FAIL rr_out[%0d] got src=%0d data=%h want src=%0d data=%h",
                                 c, wb_retire_src, rf_wdata, c % 3, exp_data);
      end
    end
    clear_inputs();
    tests_run++;
    if (wb_retire_count !== 64'd6) begin
      tests_failed++; $display("FAIL rr_count got=%0d want=6", wb_retire_count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_src(0, 1, 0, 5'd1, 64'h1, 64'h100, 1);
    next_cycle();                          // rr_ptr -> 1
    set_src(0, 1, 1, 5'd2, 64'h2, 64'h104, 1);
    set_src(1, 1, 0, 5'd3, 64'h3, 64'h200, 1);
    set_src(2, 1, 0, 5'd4, 64'h4, 64'h300, 1);
    #1;
    tests_run++;
    if (rdy !== 3'b001) begin
      tests_failed++; $display("FAIL hipri_ready got=%b want=001", rdy);
    end
    next_cycle();                          // rr_ptr stays 1
    set_src(0, 1, 0, 5'd5, 64'h5, 64'h108, 1);
    #1;
    tests_run++;
    if (rdy !== 3'b010) begin
      tests_failed++; $display("FAIL after_hipri_ready got=%b want=010", rdy);
    end
    next_cycle();                          // rr_ptr -> 2
    tests_run++;
    if ({wb_retire_src, rf_wdata} !== {2'd1, 64'h3}) begin
      tests_failed++; $display("FAIL after_hipri_out got src=%0d data=%h want 1 3", wb_retire_src, rf_wdata);
    end
    set_src(1, 1, 1, 5'd6, 64'h6, 64'h204, 1);
    set_src(2, 1, 1, 5'd4, 64'h4, 64'h300, 1);
    #1;
    tests_run++;
    if (rdy !== 3'b010) begin
      tests_failed++; $display("FAIL hipri_lowest_ready got=%b want=010", rdy);
    end
    next_cycle();                          // rr_ptr stays 2, count = 4
    clear_inputs();
  endtask

  task automatic test_stall();
    for (int s = 0; s < 3; s++) set_src(s, 1, (s == 2), 5'(s + 10), 64'hA0 + 64'(s), 64'hB0 + 64'(s), 1);
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (rdy !== 3'b000) begin
        tests_failed++; $display("FAIL stall_ready[%0d] got=%b want=000", c, rdy);
      end
      next_cycle();
      tests_run++;
      if ({rf_wen, wb_retire_valid, wb_retire_count} !== {1'b0, 1'b0, 64'd4}) begin
        tests_failed++; $display("FAIL stall_out[%0d] got wen=%b rv=%b cnt=%0d want 0 0 4",
                                 c, rf_wen, wb_retire_valid, wb_retire_count);
      end
    end
    wb_stall = 1'b0;
    md_hp = 1'b0;
    #1;
    tests_run++;
    if (rdy !== 3'b100) begin
      tests_failed++; $display("FAIL resume_ready got=%b want=100", rdy);
    end
    next_cycle();
    clear_inputs();
    tests_run++;
    if ({rf_wen, wb_retire_src, rf_wdst, wb_retire_count} !== {1'b1, 2'd2, 5'd12, 64'd5}) begin
      tests_failed++; $display("FAIL resume_out got wen=%b src=%0d dst=%0d cnt=%0d want 1 2 12 5",
                               rf_wen, wb_retire_src, rf_wdst, wb_retire_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_src(0, 1, 0, 5'd7, 64'h77, 64'h700, 1);
    next_cycle();
    next_cycle();
    clear_inputs();
    tests_run++;
    if ({rf_wen, wb_retire_valid, wb_retire_count} !== {1'b1, 1'b1, 64'd2}) begin
      tests_failed++; $display("FAIL pre_areset got wen=%b rv=%b cnt=%0d want 1 1 2",
                               rf_wen, wb_retire_valid, wb_retire_count);
    end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({rf_wen, wb_retire_valid, wb_retire_count, rf_wdata} !== {1'b0, 1'b0, 64'd0, 64'd0}) begin
      tests_failed++; $display("FAIL areset got wen=%b rv=%b cnt=%0d wdata=%h want 0 0 0 0",
                               rf_wen, wb_retire_valid, wb_retire_count, rf_wdata);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_round_robin();
    test_priority();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
